// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_CNT_W = 32;
  localparam int WAIT_CNT_W = 8;

  // Memory handshake state: free-running or frozen waiting for the cache.
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

  // Per-cycle pipeline register controls produced by the priority logic.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } hz_ctrl_t;

  // A load in EX whose (non-x0) destination feeds either ID source register.
  function automatic logic load_use_hit(
    input logic                  ex_memread,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [REG_ADDR_W-1:0] id_rs1,
    input logic [REG_ADDR_W-1:0] id_rs2
  );
    return ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_W
) (
  input  logic             clk_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Clear has precedence; otherwise count qualifying cycles.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: load-use bubbles,
// taken-branch flushes, data-cache request/ack handshake with a sticky
// timeout watchdog. Define PIPE_PERF_CNT_EN to build the stall/bubble/flush
// performance counters; otherwise the counter ports read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  cache_ack_i,
  output logic                  cache_req_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  mem_stall_o,
  output logic                  err_o,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] bubble_cnt_o,
  output logic [PERF_CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_L = (WAIT_CNT_W+1)'(TIMEOUT);

  ctrl_state_e           state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  err_q;

  logic     in_wait;
  logic     mem_stall;
  logic     cache_req;
  logic     hazard;
  logic     wait_at_limit;
  hz_ctrl_t ctrl;

  assign in_wait   = (state == ST_MEM_WAIT);
  assign hazard    = load_use_hit(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i);
  // Freeze while a miss is outstanding; the ack cycle itself already advances.
  assign mem_stall = in_wait ? ~cache_ack_i : (mem_req_i & ~cache_ack_i);
  assign cache_req = in_wait | mem_req_i;

  // This non-acked wait cycle brings the wait count up to the timeout.
  assign wait_at_limit = (({1'b0, wait_cnt} + {{WAIT_CNT_W{1'b0}}, 1'b1}) >= TIMEOUT_L);

  // Priority resolution: memory freeze, then load-use bubble, then branch flush.
  always_comb begin
    ctrl = '0;
    if (mem_stall) begin
      // Everything holds; a pending hazard or flush re-evaluates after release.
      ctrl = '0;
    end else if (hazard) begin
      ctrl.id_ex_bubble = 1'b1;
    end else begin
      ctrl.pc_write    = 1'b1;
      ctrl.if_id_write = 1'b1;
      ctrl.if_id_flush = branch_taken_i;
    end
  end

  // Handshake FSM plus watchdog; the FSM never aborts a slow access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req_i && !cache_ack_i) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (cache_ack_i) begin
            state <= ST_RUN;
          end else begin
            if (wait_cnt != '1) begin
              wait_cnt <= wait_cnt + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
            end
            if (wait_at_limit) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Every output is forced low while reset is held.
  assign cache_req_o    = cache_req        & ~rst_i;
  assign mem_stall_o    = mem_stall        & ~rst_i;
  assign pc_write_o     = ctrl.pc_write    & ~rst_i;
  assign if_id_write_o  = ctrl.if_id_write & ~rst_i;
  assign if_id_flush_o  = ctrl.if_id_flush & ~rst_i;
  assign id_ex_bubble_o = ctrl.id_ex_bubble & ~rst_i;
  assign err_o          = err_q            & ~rst_i;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt;
  logic [PERF_CNT_W-1:0] bubble_cnt;
  logic [PERF_CNT_W-1:0] flush_cnt;

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (mem_stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (ctrl.id_ex_bubble),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (ctrl.if_id_flush),
    .cnt   (flush_cnt)
  );

  assign stall_cnt_o  = rst_i ? '0 : stall_cnt;
  assign bubble_cnt_o = rst_i ? '0 : bubble_cnt;
  assign flush_cnt_o  = rst_i ? '0 : flush_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule
